// File: rtl/axi_wr_rr_sched.sv
`default_nettype none
//--------------------------------------------------------------------------
// axi_wr_rr_sched: round-robin write scheduler; the grant is held from AW to B
// Rev 1.0
//--------------------------------------------------------------------------
module axi_wr_rr_sched #(
    parameter int NUM_M  = 3,
    parameter int ID_W   = 4,
    parameter int MID_W  = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_M*ID_W-1:0]          awid_i,
    input  logic [NUM_M*ADDR_W-1:0]        awaddr_i,
    input  logic [NUM_M*LEN_W-1:0]         awlen_i,
    input  logic [NUM_M-1:0]               awvalid_i,
    output logic [NUM_M-1:0]               awready_o,
    input  logic [NUM_M*DATA_W-1:0]        wdata_i,
    input  logic [NUM_M*(DATA_W/8)-1:0]    wstrb_i,
    input  logic [NUM_M-1:0]               wlast_i,
    input  logic [NUM_M-1:0]               wvalid_i,
    output logic [NUM_M-1:0]               wready_o,
    output logic [NUM_M-1:0]               bvalid_o,
    input  logic [NUM_M-1:0]               bready_i,
    output logic [1:0]                     bresp_o,
    output logic [MID_W+ID_W-1:0]          awid_s_o,
    output logic [ADDR_W-1:0]              awaddr_s_o,
    output logic [LEN_W-1:0]               awlen_s_o,
    output logic                           awvalid_s_o,
    input  logic                           awready_s_i,
    output logic [DATA_W-1:0]              wdata_s_o,
    output logic [DATA_W/8-1:0]            wstrb_s_o,
    output logic                           wlast_s_o,
    output logic                           wvalid_s_o,
    input  logic                           wready_s_i,
    input  logic [1:0]                     bresp_s_i,
    input  logic                           bvalid_s_i,
    output logic                           bready_s_o,
    output logic [NUM_M-1:0]               grant_o,
    output logic                           len_err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] gidx, gidx_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cand;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic             found;
    logic             w_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gidx  <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            gidx  <= gidx_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        gidx_nx     = gidx;
        ptr_nx      = ptr;
        cnt_nx      = cnt;
        pick        = '0;
        found       = 1'b0;
        cand        = '0;
        w_hs        = 1'b0;
        awready_o   = '0;
        wready_o    = '0;
        bvalid_o    = '0;
        bresp_o     = '0;
        awid_s_o    = '0;
        awaddr_s_o  = '0;
        awlen_s_o   = '0;
        awvalid_s_o = 1'b0;
        wdata_s_o   = '0;
        wstrb_s_o   = '0;
        wlast_s_o   = 1'b0;
        wvalid_s_o  = 1'b0;
        bready_s_o  = 1'b0;
        grant_o     = '0;
        len_err_o   = 1'b0;

        // Search ptr, ptr+1, ... and keep the first requester found.
        for (int k = 0; k < NUM_M; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_M)) begin
                cand = cand - (IDX_W+1)'(NUM_M);
            end
            if (!found && awvalid_i[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end

        if (state != IDLE) begin
            grant_o[gidx] = 1'b1;
        end

        case (state)
            IDLE: begin
                if (found) begin
                    gidx_nx  = pick;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                awid_s_o       = {MID_W'(gidx), awid_i[gidx*ID_W +: ID_W]};
                awaddr_s_o     = awaddr_i[gidx*ADDR_W +: ADDR_W];
                awlen_s_o      = awlen_i[gidx*LEN_W +: LEN_W];
                awvalid_s_o    = awvalid_i[gidx];
                awready_o[gidx] = awready_s_i;
                if (awvalid_i[gidx] && awready_s_i) begin
                    cnt_nx   = awlen_i[gidx*LEN_W +: LEN_W];
                    state_nx = DATA;
                end
            end
            DATA: begin
                w_hs           = wvalid_i[gidx] && wready_s_i;
                wdata_s_o      = wdata_i[gidx*DATA_W +: DATA_W];
                wstrb_s_o      = wstrb_i[gidx*STRB_W +: STRB_W];
                wlast_s_o      = (cnt == '0);
                wvalid_s_o     = wvalid_i[gidx];
                wready_o[gidx] = wready_s_i;
                // The master's own WLAST is only audited; AWLEN sets the burst.
                len_err_o      = w_hs && (wlast_i[gidx] != (cnt == '0));
                if (w_hs) begin
                    if (cnt == '0) begin
                        state_nx = RESP;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
            end
            RESP: begin
                bvalid_o[gidx] = bvalid_s_i;
                bready_s_o     = bready_i[gidx];
                bresp_o        = bresp_s_i;
                if (bvalid_s_i && bready_i[gidx]) begin
                    ptr_nx   = (gidx == IDX_W'(NUM_M - 1)) ? '0 : gidx + 1'b1;
                    gidx_nx  = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/axi_wr_rr_sched.md
Name: axi_wr_rr_sched

Overview:
- Write-path scheduler for the shared slave port of the AXI interconnect.
- Arbitrates round-robin among NUM_M masters at transaction granularity.
- Once a master's AW is granted, the grant is held through its full W burst and the matching B response, so no write interleaving reaches the slave.
- Generates WLAST locally from AWLEN and prefixes AWID with the master index. This matches the read-side arbiter's ID scheme so slave-side IDs stay unique.

Parameters:
NUM_M, 3, number of masters (index 0..NUM_M-1)
ID_W, 4, master-side ID width
MID_W, 4, master-index prefix width; slave-side ID width = MID_W+ID_W
ADDR_W, 32, address width
LEN_W, 4, AWLEN width
DATA_W, 32, write data width; strobe width DATA_W/8

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
awid_i  in  NUM_M*ID_W  per-master AWID, master i at slice i
awaddr_i  in  NUM_M*ADDR_W  per-master AWADDR
awlen_i  in  NUM_M*LEN_W  per-master AWLEN
awvalid_i  in  NUM_M  per-master AWVALID
awready_o  out  NUM_M  per-master AWREADY
wdata_i  in  NUM_M*DATA_W  per-master WDATA
wstrb_i  in  NUM_M*DATA_W/8  per-master WSTRB
wlast_i  in  NUM_M  per-master WLAST; checked only, never forwarded
wvalid_i  in  NUM_M  per-master WVALID
wready_o  out  NUM_M  per-master WREADY
bvalid_o  out  NUM_M  per-master BVALID
bready_i  in  NUM_M  per-master BREADY
bresp_o  out  2  BRESP, broadcast to all masters
awid_s_o  out  MID_W+ID_W  {granted index, AWID}
awaddr_s_o  out  ADDR_W  slave AWADDR
awlen_s_o  out  LEN_W  slave AWLEN
awvalid_s_o  out  1  slave AWVALID
awready_s_i  in  1  slave AWREADY
wdata_s_o  out  DATA_W  slave WDATA
wstrb_s_o  out  DATA_W/8  slave WSTRB
wlast_s_o  out  1  locally generated WLAST
wvalid_s_o  out  1  slave WVALID
wready_s_i  in  1  slave WREADY
bresp_s_i  in  2  slave BRESP
bvalid_s_i  in  1  slave BVALID
bready_s_o  out  1  slave BREADY
grant_o  out  NUM_M  one-hot current grant; 0 in IDLE
len_err_o  out  1  one-cycle pulse on WLAST mismatch

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; ptr=0; gnt=0; beat counter cnt=0.
  - Every output is 0, including muxed data fields.
  - A reset asserted mid-transaction abandons it immediately; the slave shares the same reset.
- FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE:
  - If any awvalid_i is set, select the first requester searching ptr, ptr+1, ... modulo NUM_M.
  - Register the selection into gnt and go to ADDR.
  - Arbitration costs one cycle; no slave valid is asserted in IDLE.
- ADDR:
  - Slave AW fields are muxed from gnt.
  - awid_s_o = {gnt index zero-extended to MID_W, awid_i[gnt]}.
  - awvalid_s_o = awvalid_i[gnt]; awready_o[gnt] = awready_s_i.
  - On AW handshake: cnt <= awlen_i[gnt], go to DATA.
  - If awvalid_i[gnt] drops before the handshake, remain in ADDR; the grant is not revoked.
- DATA:
  - W fields muxed from gnt; wvalid_s_o = wvalid_i[gnt]; wready_o[gnt] = wready_s_i.
  - wlast_s_o = (cnt==0).
  - Each W handshake: if cnt!=0, cnt decrements; if cnt==0, go to RESP.
  - Without a handshake, cnt holds and data passes through combinationally.
  - len_err_o pulses on any handshake where wlast_i[gnt] != (cnt==0). The burst length follows AWLEN regardless.
- RESP:
  - bvalid_o[gnt] = bvalid_s_i; bready_s_o = bready_i[gnt]; bresp_o = bresp_s_i.
  - On B handshake: ptr <= gnt+1 (wrapping at NUM_M-1 to 0), gnt <= 0, go to IDLE.
- Non-granted masters: awready_o, wready_o and bvalid_o are always 0.
- All ready/valid outputs are combinational from state, gnt and the inputs. No cross-signal dependency is introduced beyond AXI rules.
- Minimum transaction: 1 (arb) + 1 (AW) + (AWLEN+1) (W) + 1 (B) cycles when the slave is always ready.
- Fairness: any continuously requesting master is granted within NUM_M transactions.
- Simultaneous requests are resolved only via ptr. New requests arriving during ADDR/DATA/RESP wait for IDLE.

Test Plan:
- Single request: m1 awvalid, awid=4'h5, awlen=3, slave always ready -> awid_s_o=8'h15; 4 W beats with wlast_s_o only on the 4th; bvalid_o=3'b010; back to IDLE; ptr=2.
- After reset, all three masters request continuously with awlen=0 -> grant order m0, m1, m2, m0; each transaction takes 4 cycles.
- Stalls: awlen=2; wready_s_i low for 3 cycles mid-burst -> cnt holds, exactly 3 handshakes, wlast_s_o on the 3rd only.
- Mismatch: awlen=3; master asserts wlast_i on beat 2 -> len_err_o pulses on beat 2 and on beat 4 (wlast_i low); burst still 4 beats.
- Reset asserted during DATA at beat 1 -> all outputs 0 in the same cycle; after release, m2 and m0 requesting -> m0 granted first (ptr=0).
- B backpressure: bready_i[gnt]=0 for 5 cycles with bvalid_s_i=1 -> stays in RESP, no new AW granted, grant_o unchanged.
